// File: rtl/if_stage_pkg.sv
// Shared CPU front-end package: fetch FSM state encoding, the canonical NOP,
// and the IF/ID pipeline register payload.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 -- the bubble instruction written into IF/ID.
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  // REQ: request outstanding; HOLD: word buffered behind a stall;
  // DRAIN: discarding a request made stale by a redirect.
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port.
//   imem_req_o   : request valid (fetch side -> memory)
//   imem_addr_o  : word-aligned fetch address, stable until ready
//   imem_ready_i : rdata valid for the current request this cycle
//   imem_rdata_i : fetched instruction word
interface if_stage_if;
  import if_stage_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture d
//   flush    : insert a bubble (wins over load and hold)
//   hold     : keep current contents; with neither load nor hold a bubble is inserted
//   d, q     : {pc, instr, valid} payload in/out
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble keeps the last pc so the register never shows a stale valid word.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: q.pc, instr: NOP_INSTR, valid: 1'b0};
    end else if (load) begin
      q <= d;
    end else if (!hold) begin
      q <= '{pc: q.pc, instr: NOP_INSTR, valid: 1'b0};
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID register.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   stall_i          : hazard stall, IF/ID and PC hold
//   redirect_i       : taken branch/jump from EX, flush and refetch
//   redirect_pc_i    : redirect target (low two bits ignored)
//   imem             : instruction-memory fetch port (master side)
//   IF_ID_pc_o/instr_o/valid_o : IF/ID register contents
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  if_stage_if.master        imem,
  output logic [XLEN-1:0]   IF_ID_pc_o,
  output logic [XLEN-1:0]   IF_ID_instr_o,
  output logic              IF_ID_valid_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] ld_instr;
  logic            ifid_load, ifid_flush, ifid_hold;
  if_id_t          ifid_d, ifid_q;

  assign redirect_tgt = redirect_pc_i & ~XLEN'(3);

  // Request is suppressed during reset so nothing is issued for an unknown PC.
  assign imem.imem_req_o  = !rst_i && (state_q != ST_HOLD);
  assign imem.imem_addr_o = pc_q;

  // State, PC, pending target and buffered word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, PC update and IF/ID control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    hold_d     = hold_q;
    ld_instr   = imem.imem_rdata_i;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          ifid_flush = 1'b1;
          if (imem.imem_ready_i) begin
            pc_d = redirect_tgt;
          end else begin
            // Keep pc_q so the in-flight address stays stable until it returns.
            tgt_d   = redirect_tgt;
            state_d = ST_DRAIN;
          end
        end else if (imem.imem_ready_i) begin
          if (stall_i) begin
            hold_d    = imem.imem_rdata_i;
            ifid_hold = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
          end
        end else begin
          ifid_hold = stall_i;
        end
      end

      ST_HOLD: begin
        if (redirect_i) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_tgt;
          state_d    = ST_REQ;
        end else if (stall_i) begin
          ifid_hold = 1'b1;
        end else begin
          ld_instr  = hold_q;
          ifid_load = 1'b1;
          pc_d      = pc_q + PC_STEP;
          state_d   = ST_REQ;
        end
      end

      ST_DRAIN: begin
        ifid_flush = 1'b1;
        if (redirect_i) begin
          tgt_d = redirect_tgt;
        end
        if (imem.imem_ready_i) begin
          pc_d    = redirect_i ? redirect_tgt : tgt_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  assign ifid_d = '{pc: pc_q, instr: ld_instr, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (ifid_load),
    .flush (ifid_flush),
    .hold  (ifid_hold),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IF_ID_pc_o    = ifid_q.pc;
  assign IF_ID_instr_o = ifid_q.instr;
  assign IF_ID_valid_o = ifid_q.valid;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): the bubble instruction placed in IF/ID.
REQ-003 clk_i  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 stall_i  in  1  hazard-detect stall; IF/ID and PC hold while high.
REQ-006 redirect_i  in  1  taken branch or jump from EX; flush and refetch.
REQ-007 redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0 internally.
REQ-008 imem_req_o  out  1  instruction-memory request valid.
REQ-009 imem_addr_o  out  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0.
REQ-010 imem_ready_i  in  1  imem_rdata_i is valid for the current request in this cycle.
REQ-011 imem_rdata_i  in  32  fetched instruction word.
REQ-012 IF_ID_pc_o  out  32  PC of the instruction held in IF/ID.
REQ-013 IF_ID_instr_o  out  32  instruction held in IF/ID (NOP_INSTR when not valid).
REQ-014 IF_ID_valid_o  out  1  IF/ID holds a real instruction.

Function
REQ-015 The FSM SHALL have three states: REQ (request outstanding), HOLD (word buffered, blocked by stall), DRAIN (discarding a request made stale by a redirect).
REQ-016 imem_req_o SHALL be 1 in REQ and DRAIN and 0 in HOLD; imem_addr_o SHALL equal pc_q.
REQ-017 In REQ with imem_ready_i=1 and no redirect_i or stall_i, the block SHALL load IF/ID with {pc_q, imem_rdata_i, valid=1}, set pc_q to pc_q+4, and stay in REQ (one instruction per cycle at zero-wait memory).
REQ-018 In REQ with imem_ready_i=1 and stall_i=1 (no redirect), the block SHALL capture imem_rdata_i in hold_q, leave IF/ID and pc_q unchanged, and go to HOLD.
REQ-019 In REQ with imem_ready_i=0 and no redirect, IF/ID SHALL hold its value when stall_i=1 and otherwise become a bubble (valid=0, instr=NOP_INSTR, pc unchanged).
REQ-020 In HOLD with stall_i=0 and no redirect, the block SHALL load IF/ID with {pc_q, hold_q, 1}, set pc_q to pc_q+4, and go to REQ; with stall_i=1 it stays in HOLD.
REQ-021 redirect_i SHALL take priority over stall_i: IF/ID becomes a bubble in the same edge.
REQ-022 Redirect in REQ with imem_ready_i=1, or in HOLD: set pc_q to the target, discard the fetched or held word, and go to REQ.
REQ-023 Redirect in REQ with imem_ready_i=0: store the target in tgt_q, keep pc_q so the address stays stable, and go to DRAIN.
REQ-024 In DRAIN, IF/ID SHALL stay a bubble; a new redirect_i SHALL overwrite tgt_q (latest wins); on imem_ready_i=1 the word SHALL be discarded, pc_q set to tgt_q (or redirect_pc_i if redirect_i is high that cycle), and the FSM SHALL go to REQ.
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-026 A bubble SHALL never be emitted with valid=1, and no fetched word SHALL be delivered twice or skipped.

Reset
REQ-027 While rst_i=1 at an edge: pc_q=RESET_PC, state=REQ, tgt_q=0, hold_q=0, IF_ID_pc_o=0, IF_ID_instr_o=NOP_INSTR, IF_ID_valid_o=0.
REQ-028 imem_req_o SHALL be 0 while rst_i=1 and SHALL rise in the first cycle after reset with imem_addr_o=RESET_PC.
REQ-029 Reset mid-operation SHALL abandon any outstanding request or buffered word; a late imem_ready_i is the memory's concern, and the block SHALL treat the next ready as belonging to RESET_PC.

Structure
REQ-030 The shared CPU package SHALL hold the FSM state encoding (REQ/HOLD/DRAIN) and the NOP_INSTR constant.
REQ-031 The IF/ID register SHALL be a sub-module, if_id_reg, with load, flush, and hold controls; the FSM and PC logic stay in if_stage.

Verification
REQ-032 Reset, then zero-wait memory (ready=1) -> addresses 0,4,8,...; IF/ID valid from the second edge after reset release, with pc=0 and instr=mem[0].
REQ-033 Memory with 2 wait cycles -> imem_addr_o stable during the wait, two bubbles per instruction, no duplicated PC.
REQ-034 stall_i=1 for 3 cycles arriving with ready=1 at pc=8 -> HOLD; IF/ID frozen at pc=4; after release, IF/ID={8, mem[8]} and the next fetch is 12.
REQ-035 redirect_i with target 0x100 while stall_i=1 in HOLD -> bubble in IF/ID; next fetch address 0x100; held word discarded.
REQ-036 redirect to 0x200 then to 0x300 during a 3-cycle wait -> DRAIN; stale word dropped; next fetch address 0x300.
REQ-037 pc_q=32'hFFFF_FFFC fetched -> next imem_addr_o=0.
